// File: rtl/memory_writeback.sv
// Writeback stage: retires execute bundles, completes loads from data memory,
// drives the register-file write port and counts retired instructions.
module memory_writeback #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] r0data_i,
  input  logic [31:0] result_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_rvalid_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        retire_o,
  output logic [31:0] retire_pc_o,
  output logic [31:0] instret_o,
  output logic        err_o
);

  localparam int unsigned TMO_W = 8;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

  typedef enum logic {IDLE, LOAD_WAIT} state_e;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [31:0]        rf_wdata_q, rf_wdata_d;
  logic               retire_q, retire_d;
  logic [31:0]        retire_pc_q, retire_pc_d;
  logic [31:0]        instret_q, instret_d;
  logic               err_q, err_d;
  logic [4:0]         ld_rd_q, ld_rd_d;
  logic [2:0]         ld_f3_q, ld_f3_d;
  logic [31:0]        ld_pc_q, ld_pc_d;
  logic [1:0]         ld_off_q, ld_off_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        writes_rd;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        ld_mis;
  logic        unused_ok;

  assign opcode    = inst_i[6:0];
  assign rd        = inst_i[11:7];
  assign writes_rd = (opcode == OPC_OP)  || (opcode == OPC_OPIMM) ||
                     (opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                     (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign unused_ok = ^{inst_i[31:22], inst_i[19:15], r0data_i[31:2]};

  // Load-data extraction from the word-aligned read data
  always_comb begin
    ld_byte = 8'h00;
    ld_half = ld_off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    ld_data = ERR_WORD;
    ld_mis  = 1'b0;
    case (ld_off_q)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    case (ld_f3_q)
      3'd0: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4: ld_data = {24'h0, ld_byte};
      3'd1: begin
        ld_mis  = ld_off_q[0];
        ld_data = ld_off_q[0] ? ERR_WORD : {{16{ld_half[15]}}, ld_half};
      end
      3'd5: begin
        ld_mis  = ld_off_q[0];
        ld_data = ld_off_q[0] ? ERR_WORD : {16'h0, ld_half};
      end
      3'd2: begin
        ld_mis  = (ld_off_q != 2'd0);
        ld_data = ld_mis ? ERR_WORD : dmem_rdata_i;
      end
      default: ld_data = ERR_WORD;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    retire_d    = 1'b0;
    retire_pc_d = retire_pc_q;
    err_d       = err_q;
    ld_rd_d     = ld_rd_q;
    ld_f3_d     = ld_f3_q;
    ld_pc_d     = ld_pc_q;
    ld_off_d    = ld_off_q;
    tmo_d       = tmo_q;

    case (state_q)
      IDLE: begin
        if (valid_i && ready_q) begin
          if (opcode == OPC_LOAD) begin
            ld_rd_d  = rd;
            ld_f3_d  = inst_i[14:12];
            ld_pc_d  = pc_i;
            ld_off_d = 2'(r0data_i[1:0] + inst_i[21:20]);
            tmo_d    = '0;
            state_d  = LOAD_WAIT;
          end else begin
            retire_d    = 1'b1;
            retire_pc_d = pc_i;
            if (writes_rd) begin
              rf_we_d    = (rd != 5'd0);
              rf_waddr_d = rd;
              rf_wdata_d = result_i;
            end
          end
        end
      end
      LOAD_WAIT: begin
        if (dmem_rvalid_i) begin
          rf_we_d     = (ld_rd_q != 5'd0);
          rf_waddr_d  = ld_rd_q;
          rf_wdata_d  = ld_data;
          err_d       = err_q | ld_mis;
          retire_d    = 1'b1;
          retire_pc_d = ld_pc_q;
          state_d     = IDLE;
        end else if (tmo_q == TMO_W'(LOAD_TIMEOUT - 1)) begin
          rf_we_d     = (ld_rd_q != 5'd0);
          rf_waddr_d  = ld_rd_q;
          rf_wdata_d  = ERR_WORD;
          err_d       = 1'b1;
          retire_d    = 1'b1;
          retire_pc_d = ld_pc_q;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d   = (state_d == IDLE);
    instret_d = instret_q + 32'(retire_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      retire_q    <= 1'b0;
      retire_pc_q <= '0;
      instret_q   <= '0;
      err_q       <= 1'b0;
      ld_rd_q     <= '0;
      ld_f3_q     <= '0;
      ld_pc_q     <= '0;
      ld_off_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      retire_q    <= retire_d;
      retire_pc_q <= retire_pc_d;
      instret_q   <= instret_d;
      err_q       <= err_d;
      ld_rd_q     <= ld_rd_d;
      ld_f3_q     <= ld_f3_d;
      ld_pc_q     <= ld_pc_d;
      ld_off_q    <= ld_off_d;
      tmo_q       <= tmo_d;
    end
  end

  assign ready_o     = ready_q;
  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign retire_o    = retire_q;
  assign retire_pc_o = retire_pc_q;
  assign instret_o   = instret_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_memory_writeback.sv
// Scoreboard bench for memory_writeback: directed bundles push expected
// retirements; a negedge monitor pops and compares each retire pulse.
module tb_memory_writeback;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] pc_i, inst_i, r0data_i, result_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_rvalid_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        retire_o;
  logic [31:0] retire_pc_o;
  logic [31:0] instret_o;
  logic        err_o;

  memory_writeback #(.LOAD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .r0data_i(r0data_i), .result_i(result_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .retire_o(retire_o), .retire_pc_o(retire_pc_o), .instret_o(instret_o),
    .err_o(err_o)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          ret_cyc[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] exp_instret = 0;
  logic        exp_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [2:0] f3, input logic [1:0] imm);
    return {10'd0, imm, 5'd0, f3, rd, op};
  endfunction

  // Monitor: every retire pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && retire_o) begin
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_retire: got pc %h expected none", retire_pc_o);
      end else begin
        e = sb.pop_front();
        exp_instret = exp_instret + 1;
        chk("rf_we", 32'(rf_we_o), 32'(e.we));
        if (e.we) begin
          chk("rf_waddr", 32'(rf_waddr_o), 32'(e.waddr));
          chk("rf_wdata", rf_wdata_o, e.wdata);
        end
        chk("retire_pc", retire_pc_o, e.pc);
        chk("err", 32'(err_o), 32'(e.err));
        chk("instret", instret_o, exp_instret);
        ret_cyc.push_back(cyc);
      end
    end else if (rst && rf_we_o) begin
      n_vec++; n_bad++;
      $display("FAIL stray_write: got rf_we 1 expected 0 (waddr %0d)", rf_waddr_o);
    end
  end

  // Issue one bundle; called and returns at a negedge
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] r0, input logic [31:0] res,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic err_new);
    exp_t x;
    int b = 0;
    while (!ready_o) begin
      @(negedge clk);
      b++;
      if (b > 100) begin
        n_vec++; n_bad++;
        $display("FAIL ready_timeout: got ready 0 expected 1");
        return;
      end
    end
    valid_i = 1'b1; pc_i = pc; inst_i = inst; r0data_i = r0; result_i = res;
    exp_err = exp_err | err_new;
    x.we = we; x.waddr = wa; x.wdata = wd; x.pc = pc; x.err = exp_err;
    sb.push_back(x);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] r0, input logic [31:0] word, input int dly,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic err_new);
    issue(pc, inst, r0, 32'h0, we, wa, wd, err_new);
    chk("ld_ready_low", 32'(ready_o), 32'd0);
    for (int i = 1; i < dly; i++) begin
      @(negedge clk);
      chk("ld_ready_low", 32'(ready_o), 32'd0);
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = word;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("ld_ready_back", 32'(ready_o), 32'd1);
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 40) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  localparam logic [6:0] LD = 7'b0000011, OPI = 7'b0010011, OP = 7'b0110011,
                         ST = 7'b0100011, BR = 7'b1100011, LUI = 7'b0110111;

  initial begin
    int k;
    int n;
    rst = 1'b0; valid_i = 1'b0; pc_i = 0; inst_i = 0; r0data_i = 0; result_i = 0;
    dmem_rdata_i = 0; dmem_rvalid_i = 1'b0;
    #2;
    chk("rst_rf_we", 32'(rf_we_o), 0);
    chk("rst_retire", 32'(retire_o), 0);
    chk("rst_instret", instret_o, 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_wdata", rf_wdata_o, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready_o), 1);

    // ADDI x5 -> 7
    issue(32'h100, mk(OPI, 5'd5, 3'd0, 2'd0), 0, 32'h7, 1, 5'd5, 32'h7, 0);
    drain();
    // rvalid while idle must be ignored
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hAAAA_5555;
    @(negedge clk); @(negedge clk);
    dmem_rvalid_i = 1'b0;

    // LB x3 off 3, rvalid 3 cycles after accept
    load(32'h104, mk(LD, 5'd3, 3'd0, 2'd0), 32'h1003, 32'h80FF_1234, 3, 1, 5'd3, 32'hFFFF_FF80, 0);
    drain();
    // Halfword/byte/word extraction, alignment errors
    load(32'h108, mk(LD, 5'd4, 3'd5, 2'd1), 32'h2001, 32'hBEEF_0001, 1, 1, 5'd4, 32'h0000_BEEF, 0);
    load(32'h10C, mk(LD, 5'd6, 3'd1, 2'd0), 32'h2002, 32'hBEEF_0001, 2, 1, 5'd6, 32'hFFFF_BEEF, 0);
    load(32'h110, mk(LD, 5'd8, 3'd4, 2'd0), 32'h2001, 32'h1234_5678, 1, 1, 5'd8, 32'h0000_0056, 0);
    load(32'h114, mk(LD, 5'd9, 3'd1, 2'd0), 32'h2000, 32'h0000_8001, 1, 1, 5'd9, 32'hFFFF_8001, 0);
    load(32'h118, mk(LD, 5'd10, 3'd2, 2'd0), 32'h2000, 32'hDEAD_BEEF, 1, 1, 5'd10, 32'hDEAD_BEEF, 0);
    load(32'h11C, mk(LD, 5'd0, 3'd2, 2'd0), 32'h2000, 32'h1111_2222, 1, 0, 5'd0, 32'h0, 0);
    load(32'h120, mk(LD, 5'd7, 3'd2, 2'd1), 32'h2000, 32'hBEEF_0001, 1, 1, 5'd7, 32'hFFFF_FFFF, 1);
    load(32'h124, mk(LD, 5'd11, 3'd3, 2'd0), 32'h2000, 32'h1234_5678, 1, 1, 5'd11, 32'hFFFF_FFFF, 0);
    drain();
    chk("err_sticky", 32'(err_o), 1);

    // LW timeout: ready returns after exactly 16 wait cycles
    issue(32'h128, mk(LD, 5'd12, 3'd2, 2'd0), 32'h3000, 0, 1, 5'd12, 32'hFFFF_FFFF, 1);
    k = 0;
    while (!ready_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'd16);
    drain();

    // Back-to-back: ADD x1, SW, ADD x0, plus LUI and BEQ
    issue(32'h200, mk(OP, 5'd1, 3'd0, 2'd0), 0, 32'h11, 1, 5'd1, 32'h11, 0);
    issue(32'h204, mk(ST, 5'd2, 3'd2, 2'd0), 0, 32'h22, 0, 5'd0, 32'h0, 0);
    issue(32'h208, mk(OP, 5'd0, 3'd0, 2'd0), 0, 32'h33, 0, 5'd0, 32'h0, 0);
    drain();
    n = ret_cyc.size();
    chk("b2b_consecutive", 32'(ret_cyc[n-1] - ret_cyc[n-3]), 32'd2);
    issue(32'h20C, mk(LUI, 5'd2, 3'd0, 2'd0), 0, 32'h1234_5000, 1, 5'd2, 32'h1234_5000, 0);
    issue(32'h210, mk(BR, 5'd9, 3'd0, 2'd0), 0, 32'h44, 0, 5'd0, 32'h0, 0);
    drain();

    // Reset in the middle of LOAD_WAIT
    issue(32'h300, mk(LD, 5'd13, 3'd2, 2'd0), 32'h4000, 0, 1, 5'd13, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb.delete();
    exp_instret = 0;
    exp_err = 0;
    chk("mid_rst_ready", 32'(ready_o), 0);
    chk("mid_rst_instret", instret_o, 0);
    chk("mid_rst_err", 32'(err_o), 0);
    chk("mid_rst_waddr", 32'(rf_waddr_o), 0);
    chk("mid_rst_pc", retire_pc_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready_o), 1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5A5A_5A5A;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_no_write", 32'(rf_we_o), 0);
      chk("post_rst_instret", instret_o, 0);
    end
    dmem_rvalid_i = 1'b0;
    issue(32'h400, mk(OPI, 5'd14, 3'd0, 2'd0), 0, 32'hCAFE_0001, 1, 5'd14, 32'hCAFE_0001, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
